// File: rtl/fifo_rd_streamer.sv
// Read-side streamer for the async FIFO: polls empty, issues read strobes, and presents words on a valid/ready stream with packet framing.
// Optional parity output o_tpar is enabled by defining FRD_PARITY_EN.
`timescale 1ns/1ps

module fifo_rd_streamer #(
    parameter int FIFO_width = 32,
    parameter int PKT_LEN    = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  i_rclk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_rempty,
    input  logic [FIFO_width-1:0] i_rdata,
    output logic                  o_rd,
    output logic [FIFO_width-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_word_cnt
`ifdef FRD_PARITY_EN
    ,
    output logic                  o_tpar
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0]       LAST_IDX = 8'(PKT_LEN - 1);
    localparam logic [7:0]       IDX_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                  state;
    logic                    in_flight;
    logic                    out_valid;
    logic [FIFO_width-1:0]   out_data;
    logic                    skid_valid;
    logic [FIFO_width-1:0]   skid_data;
    logic [7:0]              pkt_idx;
`ifdef FRD_PARITY_EN
    logic                    out_par;
    logic                    skid_par;
    logic                    in_par;
`endif

    logic       pop;
    logic       push;
    logic [2:0] committed;
    logic       issue;
    logic       drained;

    // in_flight marks the cycle in which i_rdata carries the word requested one cycle earlier;
    // that word lands at this edge, so it counts against the buffer but not as an outstanding read.
    assign pop       = out_valid && i_tready;
    assign push      = in_flight;
    assign committed = 3'(out_valid) + 3'(skid_valid) + 3'(in_flight);
    assign issue     = (state == RUN) && i_en && !i_rempty && !o_rd && ((committed + 3'd1) <= 3'd2);
    assign drained   = !o_rd && !in_flight && !out_valid && !skid_valid;

    assign o_tdata  = out_data;
    assign o_tvalid = out_valid;
    assign o_tlast  = out_valid && (pkt_idx == LAST_IDX);
`ifdef FRD_PARITY_EN
    assign in_par   = ^i_rdata;
    assign o_tpar   = out_par;
`endif

    always_ff @(posedge i_rclk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_rd       <= 1'b0;
            o_busy     <= 1'b0;
            in_flight  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            pkt_idx    <= '0;
            o_word_cnt <= '0;
`ifdef FRD_PARITY_EN
            out_par    <= 1'b0;
            skid_par   <= 1'b0;
`endif
        end else begin
            o_rd      <= issue;
            in_flight <= o_rd;

            case (state)
                IDLE: begin
                    if (i_en) begin
                        state  <= RUN;
                        o_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (!i_en) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_en) begin
                        state <= RUN;
                    end else if (drained) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            // Two-slot buffer: out_* is the stream head, skid_* holds the word behind it.
            if (pop) begin
                if (skid_valid) begin
                    out_data <= skid_data;
`ifdef FRD_PARITY_EN
                    out_par  <= skid_par;
`endif
                    if (push) begin
                        skid_data <= i_rdata;
`ifdef FRD_PARITY_EN
                        skid_par  <= in_par;
`endif
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end else if (push) begin
                    out_data <= i_rdata;
`ifdef FRD_PARITY_EN
                    out_par  <= in_par;
`endif
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (push) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= i_rdata;
`ifdef FRD_PARITY_EN
                    out_par   <= in_par;
`endif
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= i_rdata;
`ifdef FRD_PARITY_EN
                    skid_par   <= in_par;
`endif
                end
            end

            if (pop) begin
                pkt_idx <= (pkt_idx == LAST_IDX) ? 8'd0 : (pkt_idx + IDX_ONE);
                if (o_word_cnt != {CNT_W{1'b1}}) begin
                    o_word_cnt <= o_word_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural FIFO read port and a stream monitor.
// Parity checks are compiled in when FRD_PARITY_EN is defined.
`timescale 1ns/1ps

module tb_fifo_rd_streamer;

    localparam int W   = 32;
    localparam int PKT = 4;
    localparam int CW  = 4;

    typedef struct {
        logic        en;
        logic        tready;
        logic        rd;
        logic        tvalid;
        logic [31:0] tdata;
        logic [3:0]  cnt;
        logic        busy;
        logic        tlast;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rempty;
    logic [W-1:0]  rdata;
    logic          rd;
    logic [W-1:0]  tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          busy;
    logic [CW-1:0] word_cnt;
`ifdef FRD_PARITY_EN
    logic          tpar;
`endif

    always #5 clk = ~clk;

    fifo_rd_streamer #(
        .FIFO_width (W),
        .PKT_LEN    (PKT),
        .CNT_W      (CW)
    ) dut (
        .i_rclk     (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_rempty   (rempty),
        .i_rdata    (rdata),
        .o_rd       (rd),
        .o_tdata    (tdata),
        .o_tvalid   (tvalid),
        .i_tready   (tready),
        .o_tlast    (tlast),
        .o_busy     (busy),
        .o_word_cnt (word_cnt)
`ifdef FRD_PARITY_EN
        ,
        .o_tpar     (tpar)
`endif
    );

    // Behavioural FIFO read port: registered data one cycle after the strobe.
    logic [31:0] mem [64];
    int          wr_ptr    = 0;
    int          rd_ptr    = 0;
    int          flush_ptr = 0;

    assign rempty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd && (rd_ptr != wr_ptr)) begin
            rdata  <= mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stream monitor: samples just after the negedge, once inputs for the next edge are settled.
    int          xfer_n          = 0;
    int          rd_n            = 0;
    int          tlast_n         = 0;
    int          last_tlast_word = 0;
    int          mdl_idx         = 0;
    logic        prev_stall      = 1'b0;
    logic        prev_rd         = 1'b0;
    logic [31:0] prev_data       = '0;
    logic [31:0] exp_word;
    int          pushed;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            xfer_n          = 0;
            rd_n            = 0;
            tlast_n         = 0;
            last_tlast_word = 0;
            mdl_idx         = 0;
            prev_stall      = 1'b0;
            prev_rd         = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(tvalid), 32'd1);
                checkOutput("stall_data", tdata, prev_data);
            end
            if (rd) begin
                rd_n++;
                checkOutput("rd_gap", 32'(prev_rd), 32'd0);
                checkOutput("rd_nonempty", 32'(rempty), 32'd0);
            end
            if (tvalid && tready) begin
                pushed = wr_ptr - flush_ptr;
                checkOutput("word_expected", 32'(xfer_n < pushed), 32'd1);
                exp_word = mem[6'(flush_ptr + xfer_n)];
                checkOutput($sformatf("word_data[%0d]", xfer_n), tdata, exp_word);
                checkOutput($sformatf("word_last[%0d]", xfer_n), 32'(tlast), 32'(mdl_idx == PKT - 1));
`ifdef FRD_PARITY_EN
                checkOutput($sformatf("word_par[%0d]", xfer_n), 32'(tpar), 32'(^exp_word));
`endif
                xfer_n++;
                if (tlast) begin
                    tlast_n++;
                    last_tlast_word = xfer_n;
                end
                mdl_idx = (mdl_idx == PKT - 1) ? 0 : mdl_idx + 1;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_rd    = rd;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic fifoPush(input logic [31:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic doReset();
        rst    = 1'b1;
        en     = 1'b0;
        tready = 1'b0;
        step();
        step();
        wr_ptr    = rd_ptr;
        flush_ptr = rd_ptr;
        rst       = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        en     = v.en;
        tready = v.tready;
        step();
    endtask

    task automatic waitXfers(input string name, input int target, input int budget);
        for (int i = 0; i < budget && xfer_n < target; i++) step();
        checkOutput(name, 32'(xfer_n), 32'(target));
    endtask

    vec_t        vecs [10];
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] wc;
    logic        found;

    initial begin
        wa = 32'hA5A5_0001;
        wb = 32'h5A5A_0002;
        wc = 32'h1234_5678;
        //           en    trdy  rd    tvalid tdata  cnt   busy  tlast
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, wa,    4'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, wa,    4'd1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, wb,    4'd1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, wb,    4'd2, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, wc,    4'd2, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, wc,    4'd3, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, wc,    4'd3, 1'b1, 1'b0};

        rdata = '0;

        // Reset values and three-word stream checked cycle by cycle
        doReset();
        checkOutput("rst_rd", 32'(rd), 32'd0);
        checkOutput("rst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("rst_tdata", tdata, 32'd0);
        checkOutput("rst_tlast", 32'(tlast), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cnt", 32'(word_cnt), 32'd0);
        fifoPush(wa);
        fifoPush(wb);
        fifoPush(wc);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("t1_rd[%0d]", i), 32'(rd), 32'(vecs[i].rd));
            checkOutput($sformatf("t1_tvalid[%0d]", i), 32'(tvalid), 32'(vecs[i].tvalid));
            if (vecs[i].tvalid) checkOutput($sformatf("t1_tdata[%0d]", i), tdata, vecs[i].tdata);
            checkOutput($sformatf("t1_cnt[%0d]", i), 32'(word_cnt), 32'(vecs[i].cnt));
            checkOutput($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(vecs[i].busy));
            checkOutput($sformatf("t1_tlast[%0d]", i), 32'(tlast), 32'(vecs[i].tlast));
        end
        checkOutput("t1_reads", 32'(rd_n), 32'd3);

        // Back-pressure: only two reads fit while stalled
        doReset();
        for (int i = 0; i < 5; i++) fifoPush(32'h0000_0100 + 32'(i));
        en     = 1'b1;
        tready = 1'b0;
        repeat (20) step();
        checkOutput("t2_reads_stalled", 32'(rd_n), 32'd2);
        checkOutput("t2_tvalid_stalled", 32'(tvalid), 32'd1);
        checkOutput("t2_tdata_stalled", tdata, 32'h0000_0100);
        tready = 1'b1;
        waitXfers("t2_xfers", 5, 60);
        checkOutput("t2_reads_total", 32'(rd_n), 32'd5);
        checkOutput("t2_cnt", 32'(word_cnt), 32'd5);

        // Packet framing with PKT_LEN=4
        doReset();
        for (int i = 0; i < 10; i++) fifoPush(32'h0000_0200 + 32'(i));
        en     = 1'b1;
        tready = 1'b1;
        waitXfers("t3_xfers10", 10, 60);
        checkOutput("t3_tlast_n10", 32'(tlast_n), 32'd2);
        checkOutput("t3_tlast_at8", 32'(last_tlast_word), 32'd8);
        fifoPush(32'h0000_020A);
        fifoPush(32'h0000_020B);
        waitXfers("t3_xfers12", 12, 30);
        checkOutput("t3_tlast_n12", 32'(tlast_n), 32'd3);
        checkOutput("t3_tlast_at12", 32'(last_tlast_word), 32'd12);

        // Drain: enable drops the cycle after a read with one word already buffered
        doReset();
        for (int i = 0; i < 4; i++) fifoPush(32'h0000_0300 + 32'(i));
        en     = 1'b1;
        tready = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = rd && tvalid;
        end
        checkOutput("t4_rd_with_buffered", 32'(found), 32'd1);
        step();
        en = 1'b0;
        checkOutput("t4_reads_at_drop", 32'(rd_n), 32'd2);
        repeat (5) step();
        checkOutput("t4_busy_draining", 32'(busy), 32'd1);
        checkOutput("t4_tvalid_draining", 32'(tvalid), 32'd1);
        tready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) step();
        checkOutput("t4_busy_idle", 32'(busy), 32'd0);
        checkOutput("t4_xfers", 32'(xfer_n), 32'd2);
        checkOutput("t4_reads_drain", 32'(rd_n), 32'd2);
        checkOutput("t4_cnt", 32'(word_cnt), 32'd2);
        en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = rd;
        end
        checkOutput("t4_resume_rd", 32'(found), 32'd1);

        // Reset with a full buffer and a live stream
        doReset();
        for (int i = 0; i < 6; i++) fifoPush(32'h0000_0400 + 32'(i));
        en     = 1'b1;
        tready = 1'b1;
        waitXfers("t5_xfers", 2, 20);
        tready = 1'b0;
        repeat (10) step();
        checkOutput("t5_tvalid_before", 32'(tvalid), 32'd1);
        checkOutput("t5_cnt_before", 32'(word_cnt), 32'd2);
        rst = 1'b1;
        step();
        checkOutput("t5_tvalid", 32'(tvalid), 32'd0);
        checkOutput("t5_cnt", 32'(word_cnt), 32'd0);
        checkOutput("t5_rd", 32'(rd), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_tlast", 32'(tlast), 32'd0);
        doReset();
        repeat (3) step();
        checkOutput("t5_idle_rd", 32'(rd), 32'd0);
        checkOutput("t5_idle_busy", 32'(busy), 32'd0);

        // Counter saturates at all-ones
        doReset();
        for (int i = 0; i < 20; i++) fifoPush(32'h0000_0500 + 32'(i));
        en     = 1'b1;
        tready = 1'b1;
        waitXfers("sat_xfers", 20, 100);
        checkOutput("sat_cnt", 32'(word_cnt), 32'd15);

`ifdef FRD_PARITY_EN
        // Parity travels with each word
        doReset();
        fifoPush(32'h0000_0001);
        fifoPush(32'h0000_0003);
        en     = 1'b1;
        tready = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = tvalid;
        end
        checkOutput("t6_first_valid", 32'(found), 32'd1);
        checkOutput("t6_first_data", tdata, 32'h0000_0001);
        checkOutput("t6_first_par", 32'(tpar), 32'd1);
        step();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = tvalid;
        end
        checkOutput("t6_second_valid", 32'(found), 32'd1);
        checkOutput("t6_second_data", tdata, 32'h0000_0003);
        checkOutput("t6_second_par", 32'(tpar), 32'd0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
